risc_regfile_ctrl: RTL

//  Front-end controller for the 16x8 register file (2 registered read ports, 1 write port).

---
 rtl/risc_rf_pkg.sv | 14 +
 rtl/risc_rr_arb2.sv | 35 +++
 rtl/risc_regfile_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/risc_rf_pkg.sv
// Shared types and constants for the register-file front-end controller.
// Optional feature macro used by the controller: RISC_RF_ZERO_EN (r0 hardwired to zero).
package risc_rf_pkg;
    localparam int RF_AW    = 4;
    localparam int RF_DW    = 8;
    localparam int RF_NREGS = 2**RF_AW;

    typedef logic [RF_AW-1:0] rf_addr_t;
    typedef logic [RF_DW-1:0] rf_data_t;

    // Writeback source indices into the arbiter request/grant vectors
    localparam int WB_ALU = 0;
    localparam int WB_LSU = 1;
endpackage

// File: rtl/risc_rr_arb2.sv
// Two-input round-robin arbiter: combinational grant, one pointer flop that
// moves to the loser only when both inputs request in the same cycle.
module risc_rr_arb2
    import risc_rf_pkg::*;
#(
    parameter int RESET_PRIO = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    logic r_ptr;
    logic w_ptr_nxt;

    always_comb begin
        o_gnt = 2'b00;
        unique case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = r_ptr ? 2'b10 : 2'b01;
            default: o_gnt = 2'b00;
        endcase
    end

    // Under contention the winner is the favoured side, so the loser is ~r_ptr
    assign w_ptr_nxt = (i_req == 2'b11) ? ~r_ptr : r_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_ptr <= RESET_PRIO[0];
        else        r_ptr <= w_ptr_nxt;
    end

endmodule

// File: rtl/risc_regfile_ctrl.sv
// Register-file front end: arbitrates ALU/LSU writeback onto the single write
// port and forwards same-cycle writes to both read ports. Macro: RISC_RF_ZERO_EN.
module risc_regfile_ctrl
    import risc_rf_pkg::*;
#(
    parameter int AW         = RF_AW,
    parameter int DW         = RF_DW,
    parameter int RESET_PRIO = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rd_req,
    input  logic [AW-1:0] rs1_addr,
    input  logic [AW-1:0] rs2_addr,
    output logic          rs_valid,
    output logic [DW-1:0] rs1,
    output logic [DW-1:0] rs2,
    input  logic          wb0_valid,
    input  logic [AW-1:0] wb0_addr,
    input  logic [DW-1:0] wb0_data,
    output logic          wb0_ready,
    input  logic          wb1_valid,
    input  logic [AW-1:0] wb1_addr,
    input  logic [DW-1:0] wb1_data,
    output logic          wb1_ready,
    output logic [AW-1:0] rf_rs1_addr,
    output logic [AW-1:0] rf_rs2_addr,
    input  logic [DW-1:0] rf_rs1,
    input  logic [DW-1:0] rf_rs2,
    output logic [AW-1:0] rf_rd_addr,
    output logic [DW-1:0] rf_rd,
    output logic          rf_rd_write
);

    logic [1:0]         w_req;
    logic [1:0]         w_gnt;
    logic               w_wr_any;
    logic [1:0][AW-1:0] w_rs_addr;
    logic [1:0][DW-1:0] w_rf_data;
    logic [1:0]         w_hit;
    logic [1:0][DW-1:0] w_rs;

    logic               r_rs_valid;
    logic [1:0]         r_fwd_sel;
    logic [1:0][DW-1:0] r_fwd_data;

    // ---------------- write side ----------------
    assign w_req[WB_ALU] = wb0_valid;
    assign w_req[WB_LSU] = wb1_valid;

    risc_rr_arb2 #(
        .RESET_PRIO (RESET_PRIO)
    ) u_wb_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .i_req (w_req),
        .o_gnt (w_gnt)
    );

    assign wb0_ready = w_gnt[WB_ALU];
    assign wb1_ready = w_gnt[WB_LSU];
    assign w_wr_any  = |w_gnt;

    always_comb begin
        rf_rd_addr = '0;
        rf_rd      = '0;
        if (w_gnt[WB_LSU]) begin
            rf_rd_addr = wb1_addr;
            rf_rd      = wb1_data;
        end else if (w_gnt[WB_ALU]) begin
            rf_rd_addr = wb0_addr;
            rf_rd      = wb0_data;
        end
    end

`ifdef RISC_RF_ZERO_EN
    // r0 writes are still acknowledged but never reach the array
    assign rf_rd_write = w_wr_any && (rf_rd_addr != '0);
`else
    assign rf_rd_write = w_wr_any;
`endif

    // ---------------- read side ----------------
    assign rf_rs1_addr  = rs1_addr;
    assign rf_rs2_addr  = rs2_addr;
    assign w_rs_addr[0] = rs1_addr;
    assign w_rs_addr[1] = rs2_addr;
    assign w_rf_data[0] = rf_rs1;
    assign w_rf_data[1] = rf_rs2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rs_valid <= 1'b0;
        else        r_rs_valid <= rd_req;
    end

    assign rs_valid = r_rs_valid;

    // The array returns old data on read-during-write, so capture the write here
    for (genvar p = 0; p < 2; p++) begin : g_port
        assign w_hit[p] = rd_req && rf_rd_write && (rf_rd_addr == w_rs_addr[p]);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_fwd_sel[p]  <= 1'b0;
                r_fwd_data[p] <= '0;
            end else begin
                r_fwd_sel[p]  <= w_hit[p];
                r_fwd_data[p] <= rf_rd;
            end
        end

`ifdef RISC_RF_ZERO_EN
        logic r_zero;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r_zero <= 1'b0;
            else        r_zero <= rd_req && (w_rs_addr[p] == '0);
        end

        assign w_rs[p] = r_zero       ? '0 :
                         r_fwd_sel[p] ? r_fwd_data[p] : w_rf_data[p];
`else
        assign w_rs[p] = r_fwd_sel[p] ? r_fwd_data[p] : w_rf_data[p];
`endif
    end

    assign rs1 = w_rs[0];
    assign rs2 = w_rs[1];

endmodule
